lockstep_checker: RTL and testbench

//  Parametrised lockstep comparator. Delays NUM_CH reference streams by DELAY cycles and compares them

---
 rtl/lockstep_pkg.sv | 37 +++
 rtl/lockstep_delay_line.sv | 44 ++++
 rtl/lockstep_checker.sv | 211 +++++++++++++++++++++
 tb/tb_lockstep_checker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// -----------------------------------------------------------------------------
// lockstep_pkg
//   Shared types and helpers for the lockstep checker.
//   - lockstep_state_t : checker FSM state encoding (WARMUP / CHECK / FAULT)
//   - first_set_idx()  : index of the lowest set bit of a channel vector. It is
//                        used to report which channel failed first within a cycle.
//   Optional feature macro used by the checker: LOCKSTEP_CAPTURE_EN.
// -----------------------------------------------------------------------------
package lockstep_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    FAULT  = 2'd2
  } lockstep_state_t;

  // Widest channel vector the index search accepts. Narrower vectors are
  // zero-extended by the caller.
  localparam int unsigned MAX_CH = 64;
  localparam int unsigned IDX_W  = 7;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] first_set_idx(input logic [MAX_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (!found && v[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// -----------------------------------------------------------------------------
// lockstep_delay_line
//   Fixed-depth register pipeline with synchronous clear. Used to delay the
//   packed reference stream {valid, data} per channel so that it lines up with
//   the late shadow stream.
//   Parameters : W     - bits per stage
//                DEPTH - number of register stages (>= 1)
//   Ports      : clk   - clock
//                rst   - synchronous active-high reset, zeroes every stage
//                clr   - synchronous clear, same effect as rst
//                d     - stage 0 input
//                q     - output of the last stage (DEPTH cycles after d)
// -----------------------------------------------------------------------------
module lockstep_delay_line
  import lockstep_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/lockstep_checker.sv
// -----------------------------------------------------------------------------
// lockstep_checker
//   Lockstep comparator between a primary core trace port (reference) and a
//   shadow core trace port. The reference stream is delayed DELAY cycles and
//   compared channel by channel against the shadow stream, which already
//   arrives DELAY cycles late. Mismatches pulse `mismatch`, drive the FSM into
//   a sticky FAULT state and bump a saturating error counter.
//
//   Parameters : WIDTH  - data bits per channel
//                NUM_CH - number of compared channels (>= 1)
//                DELAY  - reference delay in cycles (>= 1)
//                CNT_W  - error counter width
//   Ports      : clk, rst        - clock, synchronous active-high reset
//                en              - enable; low holds the checker in WARMUP and
//                                  flushes the delay line
//                ref_valid/data  - reference stream, channel c at [c*WIDTH +: WIDTH]
//                dut_valid/data  - shadow stream, same packing
//                clear_err       - pulse: leave FAULT, clear counter and capture
//                equal           - registered per-channel compare result
//                mismatch        - registered pulse, any channel mismatched
//                fault           - high while in FAULT
//                err_count       - saturating count of mismatch cycles
//                cap_ch/ref/dut  - first-mismatch capture (channel, delayed
//                                  reference data, shadow data)
//   Macro      : LOCKSTEP_CAPTURE_EN builds the capture registers; without it
//                the cap_* outputs are constant 0.
// -----------------------------------------------------------------------------
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  parameter int DELAY  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         ref_valid,
  input  logic [NUM_CH*WIDTH-1:0]   ref_data,
  input  logic [NUM_CH-1:0]         dut_valid,
  input  logic [NUM_CH*WIDTH-1:0]   dut_data,
  input  logic                      clear_err,
  output logic [NUM_CH-1:0]         equal,
  output logic                      mismatch,
  output logic                      fault,
  output logic [CNT_W-1:0]          err_count,
  output logic [$clog2(NUM_CH):0]   cap_ch,
  output logic [WIDTH-1:0]          cap_ref,
  output logic [WIDTH-1:0]          cap_dut
);

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int WU_W  = $clog2(DELAY) + 1;
  localparam int SLOT  = WIDTH + 1;
  localparam int LINE_W = NUM_CH * SLOT;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  lockstep_state_t   state_q, state_d;
  logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
  logic              compare_en;

  logic [LINE_W-1:0] line_in, line_out;
  logic [NUM_CH-1:0] d_valid;
  logic [WIDTH-1:0]  d_data [NUM_CH];
  logic [WIDTH-1:0]  dut_ch [NUM_CH];
  logic [NUM_CH-1:0] ok_p0;
  logic              any_fail_p0;

  // ---- stage p0: reference delay line and combinational compare ----
  // Dropping en flushes the line so stale reference data can never be
  // compared once the checker comes back.
  lockstep_delay_line #(
    .W     (LINE_W),
    .DEPTH (DELAY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .clr (!en),
    .d   (line_in),
    .q   (line_out)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign line_in[c*SLOT +: SLOT] = {ref_valid[c], ref_data[c*WIDTH +: WIDTH]};
    assign d_valid[c] = line_out[c*SLOT + WIDTH];
    assign d_data[c]  = line_out[c*SLOT +: WIDTH];
    assign dut_ch[c]  = dut_data[c*WIDTH +: WIDTH];
    // Valids must agree; data only matters when both sides are valid.
    assign ok_p0[c]   = (d_valid[c] == dut_valid[c]) &&
                        (!d_valid[c] || (d_data[c] == dut_ch[c]));
  end

  assign any_fail_p0 = compare_en && !(&ok_p0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WARMUP;
      wu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wu_cnt_q <= wu_cnt_d;
    end
  end

  // FSM: next state. WARMUP spends exactly DELAY enabled cycles so the delay
  // line is full of live reference data before the first compare.
  always_comb begin
    state_d  = state_q;
    wu_cnt_d = wu_cnt_q;
    if (!en) begin
      state_d  = WARMUP;
      wu_cnt_d = '0;
    end else begin
      case (state_q)
        WARMUP: begin
          if (wu_cnt_q == WU_W'(DELAY - 1)) begin
            state_d  = CHECK;
            wu_cnt_d = '0;
          end else begin
            wu_cnt_d = wu_cnt_q + WU_W'(1);
          end
        end
        CHECK: begin
          if (any_fail_p0) state_d = FAULT;
        end
        FAULT: begin
          // A fresh mismatch outranks clear_err.
          if (!any_fail_p0 && clear_err) state_d = CHECK;
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    compare_en = en && (state_q != WARMUP);
    fault      = (state_q == FAULT);
  end

  // ---- stage p1: registered compare results and error counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      equal     <= '1;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      equal    <= compare_en ? ok_p0 : '1;
      mismatch <= any_fail_p0;
      if (any_fail_p0) begin
        err_count <= clear_err ? CNT_W'(1) : sat_inc(err_count);
      end else if (clear_err) begin
        err_count <= '0;
      end
    end
  end

`ifdef LOCKSTEP_CAPTURE_EN
  logic              cap_held_q;
  logic              cap_load, cap_clear;
  logic [NUM_CH-1:0] fail_vec, fail_1h;
  logic [WIDTH-1:0]  sel_ref, sel_dut;

  // Isolate the lowest failing channel and mux its data with a one-hot select.
  always_comb begin
    fail_vec = ~ok_p0;
    fail_1h  = fail_vec & (~fail_vec + NUM_CH'(1));
    sel_ref  = '0;
    sel_dut  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_ref |= {WIDTH{fail_1h[c]}} & d_data[c];
      sel_dut |= {WIDTH{fail_1h[c]}} & dut_ch[c];
    end
  end

  // Only the first mismatch is kept; clear_err in FAULT re-arms, and a
  // mismatch in that same cycle reloads immediately.
  assign cap_clear = clear_err && (state_q == FAULT);
  assign cap_load  = any_fail_p0 && (!cap_held_q || cap_clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_held_q <= 1'b0;
      cap_ch     <= '0;
      cap_ref    <= '0;
      cap_dut    <= '0;
    end else if (cap_load) begin
      cap_held_q <= 1'b1;
      cap_ch     <= CH_W'(first_set_idx(MAX_CH'(fail_vec)));
      cap_ref    <= sel_ref;
      cap_dut    <= sel_dut;
    end else if (cap_clear) begin
      cap_held_q <= 1'b0;
      cap_ch     <= '0;
      cap_ref    <= '0;
      cap_dut    <= '0;
    end
  end
`else
  assign cap_ch  = '0;
  assign cap_ref = '0;
  assign cap_dut = '0;
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
module tb_lockstep_checker;
  import lockstep_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, clear_err;
  logic [1:0]  ref_valid, dut_valid;
  logic [63:0] ref_data, dut_data;

  logic [1:0]  eq_a, eq_b;
  logic        mis_a, mis_b, flt_a, flt_b;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cch_a, cch_b;
  logic [31:0] cref_a, cref_b, cdut_a, cdut_b;

  always #5 clk = ~clk;

  lockstep_checker #(.WIDTH(32), .NUM_CH(2), .DELAY(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .ref_valid(ref_valid), .ref_data(ref_data),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .clear_err(clear_err),
    .equal(eq_a), .mismatch(mis_a), .fault(flt_a), .err_count(cnt_a),
    .cap_ch(cch_a), .cap_ref(cref_a), .cap_dut(cdut_a)
  );

  lockstep_checker #(.WIDTH(32), .NUM_CH(2), .DELAY(5), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .ref_valid(ref_valid), .ref_data(ref_data),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .clear_err(clear_err),
    .equal(eq_b), .mismatch(mis_b), .fault(flt_b), .err_count(cnt_b),
    .cap_ch(cch_b), .cap_ref(cref_b), .cap_dut(cdut_b)
  );

  typedef struct {
    bit          is_b;
    string       name;
    logic [1:0]  eq;
    logic        mis;
    logic        flt;
    logic [7:0]  cnt;
    bit          chk_cap;
    logic [1:0]  cch;
    logic [31:0] cref;
    logic [31:0] cdut;
  } exp_t;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] r0, r1;
    logic [1:0]  dv;
    logic [31:0] d0, d1;
    bit          clr;
    logic [1:0]  eq;
    logic        mis, flt;
    logic [7:0]  cnt;
    logic [1:0]  cch;
    logic [31:0] cref, cdut;
  } vec_t;

  exp_t        sbq[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [1:0]  hv [3];
  logic [63:0] hd [3];

  task automatic push_a(input string name, input logic [1:0] eq, input logic mis,
                        input logic flt, input logic [7:0] cnt, input logic [1:0] cch,
                        input logic [31:0] cref, input logic [31:0] cdut);
    exp_t e;
    e.is_b = 1'b0; e.name = name; e.eq = eq; e.mis = mis; e.flt = flt; e.cnt = cnt;
    e.chk_cap = 1'b1;
`ifdef LOCKSTEP_CAPTURE_EN
    e.cch = cch; e.cref = cref; e.cdut = cdut;
`else
    e.cch = 2'd0; e.cref = 32'd0; e.cdut = 32'd0;
    if (cch != 2'd0 || cref != 32'd0 || cdut != 32'd0) e.chk_cap = 1'b1;
`endif
    sbq.push_back(e);
  endtask

  task automatic push_b(input string name, input logic [1:0] eq, input logic mis,
                        input logic flt, input logic [7:0] cnt);
    exp_t e;
    e.is_b = 1'b1; e.name = name; e.eq = eq; e.mis = mis; e.flt = flt; e.cnt = cnt;
    e.chk_cap = 1'b0; e.cch = 2'd0; e.cref = 32'd0; e.cdut = 32'd0;
    sbq.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [1:0]  geq, gch;
    logic        gm, gf;
    logic [7:0]  gc;
    logic [31:0] gr, gd;
    bit          bad;
    if (e.is_b) begin
      geq = eq_b; gm = mis_b; gf = flt_b; gc = cnt_b; gch = cch_b; gr = cref_b; gd = cdut_b;
    end else begin
      geq = eq_a; gm = mis_a; gf = flt_a; gc = cnt_a; gch = cch_a; gr = cref_a; gd = cdut_a;
    end
    bad = (geq !== e.eq) || (gm !== e.mis) || (gf !== e.flt) || (gc !== e.cnt);
    if (e.chk_cap) bad = bad || (gch !== e.cch) || (gr !== e.cref) || (gd !== e.cdut);
    n_vec++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got eq=%b mis=%b fault=%b cnt=%0d cap=%0d/%h/%h, want eq=%b mis=%b fault=%b cnt=%0d cap=%0d/%h/%h",
               e.name, geq, gm, gf, gc, gch, gr, gd, e.eq, e.mis, e.flt, e.cnt, e.cch, e.cref, e.cdut);
    end
  endtask

  // Advance one clock, then compare everything queued for this edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e);
    end
    if (rst || !en) begin
      for (int i = 0; i < 3; i++) begin hv[i] = 2'b00; hd[i] = 64'd0; end
    end else begin
      hv[2] = hv[1]; hd[2] = hd[1];
      hv[1] = hv[0]; hd[1] = hd[0];
      hv[0] = ref_valid; hd[0] = ref_data;
    end
  endtask

  task automatic idle_inputs();
    ref_valid = 2'b00; ref_data = 64'd0;
    dut_valid = 2'b00; dut_data = 64'd0;
    clear_err = 1'b0;
  endtask

  task automatic garbage_dut();
    dut_valid = 2'b11;
    dut_data  = {$urandom(), $urandom()};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [11];
    int   cnt_e;

    for (int i = 0; i < 3; i++) begin hv[i] = 2'b00; hd[i] = 64'd0; end
    rst = 1'b1; en = 1'b1;
    idle_inputs();

    // Reset state
    for (int i = 0; i < 2; i++) begin
      ref_valid = 2'($urandom_range(0, 3)); ref_data = {$urandom(), $urandom()};
      garbage_dut();
      push_a("reset_a", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'd0, 32'd0);
      push_b("reset_b", 2'b11, 1'b0, 1'b0, 8'd0);
      step();
    end
    rst = 1'b0;
    idle_inputs();

    // Test 1: shadow stream equals reference delayed by 3
    for (int i = 0; i < 20; i++) begin
      ref_valid = 2'($urandom_range(0, 3));
      ref_data  = {$urandom(), $urandom()};
      dut_valid = hv[2]; dut_data = hd[2];
      push_a("stream_match", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'd0, 32'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      ref_valid = 2'b00; ref_data = 64'd0;
      dut_valid = hv[2]; dut_data = hd[2];
      push_a("stream_flush", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'd0, 32'd0);
      step();
    end

    // Tests 2, 3, 5: table-driven, row k compares against row k-3's reference
    //          rv     r0             r1     dv     d0             d1             clr   eq     mis   flt   cnt   cch   cref   cdut
    vt[0]  = '{2'b11, 32'hF0F0_0000, 32'h0, 2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0,  32'h0};
    vt[1]  = '{2'b11, 32'hA5,        32'h5A, 2'b00, 32'h0,        32'h0,         1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0,  32'h0};
    vt[2]  = '{2'b01, 32'h0,         32'h0, 2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0,  32'h0};
    vt[3]  = '{2'b00, 32'h0,         32'h0, 2'b11, 32'hF0F0_0000, 32'hDEAD_BEEF, 1'b0, 2'b01, 1'b1, 1'b1, 8'd1, 2'd1, 32'h0,  32'hDEAD_BEEF};
    vt[4]  = '{2'b00, 32'h77,        32'h0, 2'b11, 32'hA5,        32'h5A,        1'b0, 2'b11, 1'b0, 1'b1, 8'd1, 2'd1, 32'h0,  32'hDEAD_BEEF};
    vt[5]  = '{2'b00, 32'h0,         32'h0, 2'b01, 32'h0,         32'h0,         1'b0, 2'b11, 1'b0, 1'b1, 8'd1, 2'd1, 32'h0,  32'hDEAD_BEEF};
    vt[6]  = '{2'b00, 32'h0,         32'h0, 2'b00, 32'h0,         32'h0,         1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0,  32'h0};
    vt[7]  = '{2'b00, 32'h0,         32'h0, 2'b01, 32'h77,        32'h0,         1'b0, 2'b10, 1'b1, 1'b1, 8'd1, 2'd0, 32'h77, 32'h77};
    vt[8]  = '{2'b00, 32'h0,         32'h0, 2'b00, 32'h0,         32'h0,         1'b0, 2'b11, 1'b0, 1'b1, 8'd1, 2'd0, 32'h77, 32'h77};
    vt[9]  = '{2'b00, 32'h0,         32'h0, 2'b10, 32'h0,         32'h1234,      1'b1, 2'b01, 1'b1, 1'b1, 8'd1, 2'd1, 32'h0,  32'h1234};
    vt[10] = '{2'b00, 32'h0,         32'h0, 2'b00, 32'h0,         32'h0,         1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0,  32'h0};
    for (int k = 0; k < 11; k++) begin
      ref_valid = vt[k].rv; ref_data = {vt[k].r1, vt[k].r0};
      dut_valid = vt[k].dv; dut_data = {vt[k].d1, vt[k].d0};
      clear_err = vt[k].clr;
      push_a($sformatf("table_row%0d", k), vt[k].eq, vt[k].mis, vt[k].flt, vt[k].cnt,
             vt[k].cch, vt[k].cref, vt[k].cdut);
      step();
    end
    idle_inputs();

    // Test 4: 300 mismatch cycles, counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      dut_valid = 2'b01;
      dut_data  = {32'h0, 32'h100 + 32'(i)};
      cnt_e = (i + 1 > 255) ? 255 : i + 1;
      push_a($sformatf("saturate_%0d", i), 2'b10, 1'b1, 1'b1, 8'(cnt_e), 2'd0, 32'h0, 32'h100);
      step();
    end
    idle_inputs();
    clear_err = 1'b1;
    push_a("sat_clear", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0, 32'h0);
    step();
    clear_err = 1'b0;
    push_a("sat_check_idle", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0, 32'h0);
    step();
    dut_valid = 2'b10; dut_data = {32'h5, 32'h0};
    push_a("sat_check_live", 2'b01, 1'b1, 1'b1, 8'd1, 2'd1, 32'h0, 32'h5);
    step();
    idle_inputs();
    clear_err = 1'b1;
    push_a("sat_check_clear", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0, 32'h0);
    step();
    idle_inputs();

    // Test 6: mid-stream reset, then warmup on the DELAY=5 instance
    for (int i = 0; i < 6; i++) begin
      ref_valid = 2'($urandom_range(0, 3)); ref_data = {$urandom(), $urandom()};
      dut_valid = hv[2]; dut_data = hd[2];
      step();
    end
    rst = 1'b1;
    garbage_dut();
    push_a("midrst_a", 2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 32'h0, 32'h0);
    push_b("midrst_b", 2'b11, 1'b0, 1'b0, 8'd0);
    step();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      garbage_dut();
      push_b($sformatf("warmup_rst_%0d", i), 2'b11, 1'b0, 1'b0, 8'd0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      push_b($sformatf("post_warmup_idle_%0d", i), 2'b11, 1'b0, 1'b0, 8'd0);
      step();
    end
    garbage_dut();
    push_b("post_warmup_live", 2'b00, 1'b1, 1'b1, 8'd1);
    step();
    idle_inputs();
    clear_err = 1'b1;
    push_b("b_clear", 2'b11, 1'b0, 1'b0, 8'd0);
    step();
    idle_inputs();
    en = 1'b0;
    push_b("en_low", 2'b11, 1'b0, 1'b0, 8'd0);
    step();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      garbage_dut();
      push_b($sformatf("warmup_en_%0d", i), 2'b11, 1'b0, 1'b0, 8'd0);
      step();
    end
    idle_inputs();
    push_b("en_idle", 2'b11, 1'b0, 1'b0, 8'd0);
    step();
    garbage_dut();
    push_b("en_live", 2'b00, 1'b1, 1'b1, 8'd1);
    step();
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
